line_pattern_gen: RTL



---
 rtl/video_pkg.sv | 24 ++
 rtl/pattern_pixel.sv | 36 +++
 rtl/line_pattern_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video pixel-source blocks: default line width,
// pattern-select encodings, colour-bar palette and the line generator FSM states.
package video_pkg;

    localparam int H_ACTIVE_DEF = 800;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd1;
    localparam logic [1:0] PAT_GRAD  = 2'd2;
    localparam logic [1:0] PAT_BARS  = 2'd3;

    // Element 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_PALETTE = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pattern_pixel.sv
// Combinational pixel function: maps (pattern, x, line, bar index) to an RGB888 value.
// The parent registers the result; bar index comes from its down-counter.
module pattern_pixel
    import video_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          CELL_LOG2 = 3,
    parameter logic [23:0] COLOR_A   = 24'hFF0000,
    parameter logic [23:0] COLOR_B   = 24'h0000FF
) (
    input  logic [1:0]        pattern,
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    input  logic [2:0]        bar_idx,
    output logic [23:0]       pix
);

    logic [7:0] grey;
    logic       unused_bits;

    // Four pixels per grey step; wider lines simply wrap the 8-bit ramp.
    assign grey        = 8'(x >> 2);
    assign unused_bits = ^{x, y};

    always_comb begin
        pix = COLOR_A;
        case (pattern)
            PAT_SOLID: pix = COLOR_A;
            PAT_CHECK: pix = (x[CELL_LOG2] ^ y[CELL_LOG2]) ? COLOR_A : COLOR_B;
            PAT_GRAD:  pix = {grey, grey, grey};
            PAT_BARS:  pix = BAR_PALETTE[bar_idx];
            default:   pix = COLOR_A;
        endcase
    end

endmodule

// File: rtl/line_pattern_gen.sv
// Test-pattern line source for the video line buffer: on each line_req edge writes
// H_ACTIVE RGB888 pixels. Define LINE_PATTERN_SCROLL_EN for a per-frame horizontal scroll.
module line_pattern_gen
    import video_pkg::*;
#(
    parameter int          H_ACTIVE  = H_ACTIVE_DEF,
    parameter int          ADDR_W    = 10,
    parameter logic [23:0] COLOR_A   = 24'hFF0000,
    parameter logic [23:0] COLOR_B   = 24'h0000FF,
    parameter int          CELL_LOG2 = 3
) (
    input  logic              clk_psram,
    input  logic              rst_n,
    input  logic              line_req,
    input  logic [ADDR_W-1:0] line_idx,
    input  logic [1:0]        pattern_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              line_done,
    output logic              overrun
`ifdef LINE_PATTERN_SCROLL_EN
    ,
    output logic [7:0]        frame_cnt
`endif
);

    localparam logic [ADDR_W-1:0] X_LAST     = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] BAR_RELOAD = ADDR_W'(H_ACTIVE / 8 - 1);

    state_t            state, state_nxt;
    logic              req_d, start;
    logic              pend, pend_nxt;
    logic              accept, ovr_set;
    logic [ADDR_W-1:0] x, x_pat, y_lat, bar_cnt;
    logic [1:0]        pat_lat;
    logic [2:0]        bar_idx;
    logic [23:0]       pix;

    assign start = line_req & ~req_d;

`ifdef LINE_PATTERN_SCROLL_EN
    logic [7:0] offset;
    assign x_pat     = x + ADDR_W'(offset);
    assign frame_cnt = offset;
`else
    assign x_pat = x;
`endif

    pattern_pixel #(
        .ADDR_W    (ADDR_W),
        .CELL_LOG2 (CELL_LOG2),
        .COLOR_A   (COLOR_A),
        .COLOR_B   (COLOR_B)
    ) u_pix (
        .pattern (pat_lat),
        .x       (x_pat),
        .y       (y_lat),
        .bar_idx (bar_idx),
        .pix     (pix)
    );

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        accept    = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start || pend) begin
                    accept    = 1'b1;
                    pend_nxt  = 1'b0;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                ovr_set = start;
                if (x == X_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // An edge here is not an overrun: the line is already finished.
                if (start) pend_nxt = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_psram or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_d     <= 1'b0;
            pend      <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            line_done <= 1'b0;
            overrun   <= 1'b0;
            x         <= '0;
            y_lat     <= '0;
            pat_lat   <= PAT_SOLID;
            bar_cnt   <= '0;
            bar_idx   <= '0;
`ifdef LINE_PATTERN_SCROLL_EN
            offset    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            req_d     <= line_req;
            pend      <= pend_nxt;
            wr_en     <= 1'b0;
            line_done <= 1'b0;
            if (ovr_set) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        y_lat   <= line_idx;
                        pat_lat <= pattern_sel;
                        x       <= '0;
                        bar_cnt <= BAR_RELOAD;
                        bar_idx <= '0;
                        busy    <= 1'b1;
`ifdef LINE_PATTERN_SCROLL_EN
                        if (line_idx == '0) offset <= offset + 8'd1;
`endif
                    end
                end
                ST_FILL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= x;
                    wr_data <= pix;
                    x       <= x + 1'b1;
                    if (bar_cnt == '0) begin
                        bar_cnt <= BAR_RELOAD;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    line_done <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
